// File: rtl/sensor_select_sequencer_if.sv
// Control/status bundle between the sensor register block (master) and the select sequencer (slave).
// timeout_cnt is present only when SENSOR_SEQ_TIMEOUT_CNT_EN is defined.
interface sensor_select_sequencer_if #(
    parameter int NUM_CH  = 8,
    parameter int TIMER_W = 20
);
    localparam int CH_W = $clog2(NUM_CH);

    logic                enable;
    logic [NUM_CH-1:0]   ch_mask;
    logic [TIMER_W-1:0]  dwell_cycles;
    logic                meas_done;
    logic [NUM_CH-1:0]   sel_n;
    logic [CH_W-1:0]     ch_idx;
    logic                ch_valid;
    logic                slot_start;
    logic                slot_timeout;
    logic                scan_wrap;
`ifdef SENSOR_SEQ_TIMEOUT_CNT_EN
    logic [7:0]          timeout_cnt;
`endif

    modport master (
        output enable, ch_mask, dwell_cycles, meas_done,
        input  sel_n, ch_idx, ch_valid, slot_start, slot_timeout, scan_wrap
`ifdef SENSOR_SEQ_TIMEOUT_CNT_EN
        , input timeout_cnt
`endif
    );

    modport slave (
        input  enable, ch_mask, dwell_cycles, meas_done,
        output sel_n, ch_idx, ch_valid, slot_start, slot_timeout, scan_wrap
`ifdef SENSOR_SEQ_TIMEOUT_CNT_EN
        , output timeout_cnt
`endif
    );
endinterface

// File: rtl/sensor_select_sequencer.sv
// Round-robin active-low sensor select with dwell timeout and deselect guard gap; optional SENSOR_SEQ_TIMEOUT_CNT_EN adds timeout_cnt.
// Latency: 1 cycle from sampled enable (or gap end) to sel_n low; all outputs registered.
// Backpressure: none; meas_done ends a slot early, enable=0 aborts to IDLE on the next edge.
module sensor_select_sequencer #(
    parameter int NUM_CH     = 8,
    parameter int TIMER_W    = 20,
    parameter int GAP_CYCLES = 500
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sensor_select_sequencer_if.slave bus
);
    localparam int CH_W     = $clog2(NUM_CH);
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

    typedef enum logic [1:0] {IDLE, SELECT, GAP} state_t;

    state_t              state_q, state_n;
    logic [TIMER_W-1:0]  timer_q, timer_n;
    logic [TIMER_W-1:0]  dwell_q, dwell_n;
    logic [GAP_W-1:0]    gap_q, gap_n;
    logic [CH_W-1:0]     ptr_q, ptr_n;
    logic                prev_q, prev_n;
    logic [NUM_CH-1:0]   sel_n_q, sel_n_n;
    logic [CH_W-1:0]     idx_q, idx_n;
    logic                valid_q, valid_n;
    logic                start_q, start_n;
    logic                tout_q, tout_n;
    logic                wrap_q, wrap_n;
    logic [CH_W-1:0]     pick;
    logic                launch;
    logic                end_slot;

    // Descending loop so the nearest enabled channel above the pointer wins;
    // i = NUM_CH revisits the pointer itself when it is the only one enabled.
    always_comb begin
        pick = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (bus.ch_mask[CH_W'((int'(ptr_q) + i) % NUM_CH)])
                pick = CH_W'((int'(ptr_q) + i) % NUM_CH);
        end
    end

    always_comb begin
        state_n  = state_q;
        timer_n  = timer_q;
        dwell_n  = dwell_q;
        gap_n    = gap_q;
        ptr_n    = ptr_q;
        prev_n   = prev_q;
        idx_n    = idx_q;
        valid_n  = valid_q;
        start_n  = 1'b0;
        tout_n   = 1'b0;
        wrap_n   = 1'b0;
        launch   = 1'b0;
        end_slot = 1'b0;
        sel_n_n  = '1;

        case (state_q)
            IDLE: begin
                valid_n = 1'b0;
                if (bus.enable && |bus.ch_mask)
                    launch = 1'b1;
            end
            SELECT: begin
                if (!bus.enable) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                end else if (bus.meas_done) begin
                    end_slot = 1'b1;
                end else if (timer_q == dwell_q - TIMER_W'(1)) begin
                    end_slot = 1'b1;
                    tout_n   = 1'b1;
                end else begin
                    timer_n = timer_q + TIMER_W'(1);
                end
            end
            GAP: begin
                if (!bus.enable) begin
                    state_n = IDLE;
                end else if (gap_q == GAP_W'(GAP_LAST)) begin
                    if (|bus.ch_mask)
                        launch = 1'b1;
                    else
                        state_n = IDLE;
                end else begin
                    gap_n = gap_q + GAP_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // With no gap, IDLE takes the next-slot decision so sel_n still passes through all ones.
        if (end_slot) begin
            valid_n = 1'b0;
            gap_n   = '0;
            state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
        end

        if (launch) begin
            state_n = SELECT;
            timer_n = '0;
            dwell_n = (bus.dwell_cycles == '0) ? TIMER_W'(1) : bus.dwell_cycles;
            idx_n   = pick;
            valid_n = 1'b1;
            start_n = 1'b1;
            wrap_n  = prev_q && (pick <= ptr_q);
            ptr_n   = pick;
            prev_n  = 1'b1;
        end

        if (valid_n)
            sel_n_n[idx_n] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            dwell_q <= TIMER_W'(1);
            gap_q   <= '0;
            ptr_q   <= CH_W'(NUM_CH - 1);
            prev_q  <= 1'b0;
            sel_n_q <= '1;
            idx_q   <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            tout_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            dwell_q <= dwell_n;
            gap_q   <= gap_n;
            ptr_q   <= ptr_n;
            prev_q  <= prev_n;
            sel_n_q <= sel_n_n;
            idx_q   <= idx_n;
            valid_q <= valid_n;
            start_q <= start_n;
            tout_q  <= tout_n;
            wrap_q  <= wrap_n;
        end
    end

    assign bus.sel_n        = sel_n_q;
    assign bus.ch_idx       = idx_q;
    assign bus.ch_valid     = valid_q;
    assign bus.slot_start   = start_q;
    assign bus.slot_timeout = tout_q;
    assign bus.scan_wrap    = wrap_q;

`ifdef SENSOR_SEQ_TIMEOUT_CNT_EN
    logic [7:0] tcnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tcnt_q <= '0;
        else if (tout_n && (tcnt_q != 8'hFF))
            tcnt_q <= tcnt_q + 8'd1;
    end

    assign bus.timeout_cnt = tcnt_q;
`endif
endmodule

// File: tb/tb_sensor_select_sequencer.sv
// Directed bench for sensor_select_sequencer: expected per-cycle outputs are queued as stimulus is applied
// and popped on each falling edge for comparison.
module tb_sensor_select_sequencer;
    typedef struct packed {
        logic [7:0] sel_n;
        logic [2:0] idx;
        logic       valid;
        logic       start;
        logic       tout;
        logic       wrap;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    vec_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   last_ch = 0;
    int   pulses = 0;
    int   cyc = 0;

    sensor_select_sequencer_if #(.NUM_CH(8), .TIMER_W(20)) bus ();

    sensor_select_sequencer #(.NUM_CH(8), .TIMER_W(20), .GAP_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic push_slot(input int ch, input int len, input bit wrap);
        vec_t v;
        for (int i = 0; i < len; i++) begin
            v.sel_n     = 8'hFF;
            v.sel_n[ch] = 1'b0;
            v.idx       = 3'(ch);
            v.valid     = 1'b1;
            v.start     = (i == 0);
            v.tout      = 1'b0;
            v.wrap      = (i == 0) && wrap;
            exp_q.push_back(v);
        end
        last_ch = ch;
    endtask

    task automatic push_gap(input int n, input bit tout);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.sel_n = 8'hFF;
            v.idx   = 3'(last_ch);
            v.valid = 1'b0;
            v.start = 1'b0;
            v.tout  = (i == 0) && tout;
            v.wrap  = 1'b0;
            exp_q.push_back(v);
        end
    endtask

    task automatic run_check(input string tag, input int n);
        vec_t obs;
        vec_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs = {bus.sel_n, bus.ch_idx, bus.ch_valid, bus.slot_start, bus.slot_timeout, bus.scan_wrap};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $error("FAIL %s cycle %0d: got %h, nothing expected", tag, i, obs);
            end else begin
                e = exp_q.pop_front();
                assert (obs === e) else begin
                    miscompares++;
                    $error("FAIL %s cycle %0d: got sel_n=%h idx=%0d v=%b st=%b to=%b wr=%b want sel_n=%h idx=%0d v=%b st=%b to=%b wr=%b",
                           tag, i, obs.sel_n, obs.idx, obs.valid, obs.start, obs.tout, obs.wrap,
                           e.sel_n, e.idx, e.valid, e.start, e.tout, e.wrap);
                end
            end
        end
    endtask

    initial begin
        bus.enable       = 1'b0;
        bus.ch_mask      = 8'h00;
        bus.dwell_cycles = 20'd10;
        bus.meas_done    = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        push_gap(1, 1'b0);
        run_check("reset", 1);

        // Full scan with dwell expiry on every slot
        bus.enable  = 1'b1;
        bus.ch_mask = 8'hFF;
        push_slot(0, 10, 1'b0);
        push_gap(4, 1'b1);
        for (int ch = 1; ch < 8; ch++) begin
            push_slot(ch, 10, 1'b0);
            push_gap(4, 1'b1);
        end
        push_slot(0, 1, 1'b1);
        run_check("scan_all", exp_q.size());
        bus.enable = 1'b0;
        push_gap(1, 1'b0);
        run_check("abort_ch0", 1);

        // Sparse mask: channels 2 and 5
        bus.enable  = 1'b1;
        bus.ch_mask = 8'h24;
        push_slot(2, 10, 1'b0);
        push_gap(4, 1'b1);
        push_slot(5, 10, 1'b0);
        push_gap(4, 1'b1);
        push_slot(2, 10, 1'b1);
        push_gap(4, 1'b1);
        push_slot(5, 1, 1'b0);
        run_check("mask_24", exp_q.size());
        bus.enable = 1'b0;
        push_gap(1, 1'b0);
        run_check("abort_ch5", 1);

        // Early meas_done in 4th cycle, then meas_done on the final dwell cycle
        bus.enable  = 1'b1;
        bus.ch_mask = 8'h03;
        push_slot(0, 4, 1'b1);
        run_check("md_early_slot", 4);
        bus.meas_done = 1'b1;
        push_gap(4, 1'b0);
        push_slot(1, 10, 1'b0);
        run_check("md_early_end", 1);
        bus.meas_done = 1'b0;
        run_check("md_gap_next", 13);
        bus.meas_done = 1'b1;
        push_gap(4, 1'b0);
        push_slot(0, 1, 1'b1);
        run_check("md_last_cycle", 1);
        bus.meas_done = 1'b0;
        run_check("md_last_gap", 4);
        bus.enable = 1'b0;
        push_gap(1, 1'b0);
        run_check("abort_md", 1);

        // dwell_cycles=0 behaves as single-cycle slots
        bus.dwell_cycles = 20'd0;
        bus.ch_mask      = 8'hFF;
        bus.enable       = 1'b1;
        push_slot(1, 1, 1'b0);
        push_gap(4, 1'b1);
        push_slot(2, 1, 1'b0);
        push_gap(4, 1'b1);
        run_check("dwell_zero", exp_q.size());
        bus.dwell_cycles = 20'd10;

        // Abort during ch3, resume at ch4, then empty mask keeps idle
        push_slot(3, 3, 1'b0);
        run_check("ch3_slot", 3);
        bus.enable = 1'b0;
        push_gap(3, 1'b0);
        run_check("abort_ch3", 3);
        bus.enable = 1'b1;
        push_slot(4, 1, 1'b0);
        run_check("resume_ch4", 1);
        bus.enable = 1'b0;
        push_gap(1, 1'b0);
        run_check("abort_ch4", 1);
        bus.ch_mask = 8'h00;
        bus.enable  = 1'b1;
        push_gap(4, 1'b0);
        run_check("mask_zero", 4);

        // Asynchronous reset mid-slot
        bus.ch_mask = 8'hFF;
        push_slot(5, 3, 1'b0);
        run_check("ch5_slot", 3);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        assert ({bus.sel_n, bus.ch_valid, bus.ch_idx} === {8'hFF, 1'b0, 3'd0}) else begin
            miscompares++;
            $error("FAIL async_reset: got sel_n=%h v=%b idx=%0d want sel_n=ff v=0 idx=0",
                   bus.sel_n, bus.ch_valid, bus.ch_idx);
        end
`ifdef SENSOR_SEQ_TIMEOUT_CNT_EN
        vectors++;
        assert (bus.timeout_cnt === 8'd0) else begin
            miscompares++;
            $error("FAIL tcnt_reset: got %0d want 0", bus.timeout_cnt);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        push_slot(0, 2, 1'b0);
        run_check("post_reset", 2);

`ifdef SENSOR_SEQ_TIMEOUT_CNT_EN
        bus.dwell_cycles = 20'd1;
        while (pulses < 8 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bus.slot_timeout) pulses++;
        end
        vectors++;
        assert (bus.timeout_cnt === 8'd8) else begin
            miscompares++;
            $error("FAIL tcnt_8: got %0d want 8 (pulses seen %0d)", bus.timeout_cnt, pulses);
        end
        while (pulses < 300 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (bus.slot_timeout) pulses++;
        end
        vectors++;
        assert (bus.timeout_cnt === 8'd255) else begin
            miscompares++;
            $error("FAIL tcnt_sat: got %0d want 255 (pulses seen %0d)", bus.timeout_cnt, pulses);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
